// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer that chains one shared WORD_W-bit
// adder slice over NWORDS cycles. Define MP_ADD_ZERO_FLAG_EN to add the zero output.
module mp_add_seq #(
  parameter int WORD_W = 16,
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sub,
  input  logic [WORD_W*NWORDS-1:0] a,
  input  logic [WORD_W*NWORDS-1:0] b,
  output logic [WORD_W-1:0]        add_a,
  output logic [WORD_W-1:0]        add_b,
  output logic                     add_cin,
  input  logic [WORD_W-1:0]        add_sum,
  input  logic                     add_cout,
  output logic                     busy,
  output logic                     done,
  output logic [WORD_W*NWORDS-1:0] result,
  output logic                     carry_out,
  output logic                     overflow
`ifdef MP_ADD_ZERO_FLAG_EN
  ,
  output logic                     zero
`endif
);

  localparam int W     = WORD_W * NWORDS;
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_sub;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
`ifdef MP_ADD_ZERO_FLAG_EN
  logic             r_nz;
`endif

  logic [WORD_W-1:0] w_word_a;
  logic [WORD_W-1:0] w_word_b;
  logic              w_last;

  // Word select and adder-slice drive; the slice sees zeros outside RUN.
  always_comb begin
    w_word_a = r_a[WORD_W*int'(r_idx) +: WORD_W];
    w_word_b = r_b[WORD_W*int'(r_idx) +: WORD_W];
    w_last   = (r_idx == LAST_IDX);
    if (r_state == S_RUN) begin
      add_a   = w_word_a;
      add_b   = w_word_b ^ {WORD_W{r_sub}};
      add_cin = r_carry;
    end else begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
    end
  end

  // Sequencer FSM: operand capture, carry chaining, result assembly and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sub     <= 1'b0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
`ifdef MP_ADD_ZERO_FLAG_EN
      r_nz      <= 1'b0;
      zero      <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_sub     <= sub;
            r_idx     <= '0;
            // Subtract is a + ~b + 1, so the chain starts with carry = sub.
            r_carry   <= sub;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
`ifdef MP_ADD_ZERO_FLAG_EN
            r_nz      <= 1'b0;
            zero      <= 1'b1;
`endif
            busy      <= 1'b1;
            r_state   <= S_RUN;
          end else begin
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_RUN: begin
          result[WORD_W*int'(r_idx) +: WORD_W] <= add_sum;
          r_carry <= add_cout;
`ifdef MP_ADD_ZERO_FLAG_EN
          r_nz    <= r_nz | (|add_sum);
`endif
          if (w_last) begin
            carry_out <= add_cout;
            // Carry into the MSB xor carry out of it.
            overflow  <= add_a[WORD_W-1] ^ add_b[WORD_W-1] ^ add_sum[WORD_W-1] ^ add_cout;
`ifdef MP_ADD_ZERO_FLAG_EN
            zero      <= ~(r_nz | (|add_sum));
`endif
            busy      <= 1'b0;
            done      <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_idx     <= r_idx + 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: table-driven and scoreboard-checked bench for mp_add_seq with a
// behavioural 16-bit adder slice (WORD_W=16, NWORDS=4).
module tb_mp_add_seq;
  localparam int WORD_W = 16;
  localparam int NWORDS = 4;
  localparam int W      = 64;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [15:0]  add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] result;
`ifdef MP_ADD_ZERO_FLAG_EN
  logic         zero;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] r;
    logic        c;
    logic        v;
  } vec_t;

  typedef struct {
    logic [63:0] r;
    logic        c;
    logic        v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[10];

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  mp_add_seq #(.WORD_W(WORD_W), .NWORDS(NWORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow)
`ifdef MP_ADD_ZERO_FLAG_EN
    ,
    .zero     (zero)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] ia, input logic [63:0] ib, input logic isub);
    logic [63:0] bb;
    logic [64:0] s;
    exp_t e;
    bb  = isub ? ~ib : ib;
    s   = {1'b0, ia} + {1'b0, bb} + {64'd0, isub};
    e.r = s[63:0];
    e.c = s[64];
    e.v = (ia[63] == bb[63]) && (s[63] != ia[63]);
    return e;
  endfunction

  // Scoreboard consumer: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        mon_e = sb.pop_front();
        chk("result", result, mon_e.r);
        chk("carry_out", {63'd0, carry_out}, {63'd0, mon_e.c});
        chk("overflow", {63'd0, overflow}, {63'd0, mon_e.v});
        chk("busy_in_done", {63'd0, busy}, 64'd0);
`ifdef MP_ADD_ZERO_FLAG_EN
        chk("zero", {63'd0, zero}, {63'd0, (mon_e.r == 64'd0)});
`endif
      end
    end
  end

  // Drive start at the current negedge, then check first RUN cycle and latency.
  task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic isub,
                       input logic [63:0] er, input logic ec, input logic ev);
    exp_t e;
    int   n;
    start = 1'b1;
    a     = ia;
    b     = ib;
    sub   = isub;
    e.r   = er;
    e.c   = ec;
    e.v   = ev;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", {63'd0, busy}, 64'd1);
    chk("add_a_w0", {48'd0, add_a}, {48'd0, ia[15:0]});
    chk("add_b_w0", {48'd0, add_b}, {48'd0, ib[15:0] ^ {16{isub}}});
    chk("add_cin_w0", {63'd0, add_cin}, {63'd0, isub});
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'd5);
  endtask

  task automatic op(input logic [63:0] ia, input logic [63:0] ib, input logic isub,
                    input logic [63:0] er, input logic ec, input logic ev);
    @(negedge clk);
    issue(ia, ib, isub, er, ec, ev);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [63:0] ra, rb;
    logic        rs;
    int          n;

    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[2] = '{64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0};
    vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};
    vecs[7] = '{64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0};
    vecs[8] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[9] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_carry_out", {63'd0, carry_out}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_add_a", {48'd0, add_a}, 64'd0);
`ifdef MP_ADD_ZERO_FLAG_EN
    chk("rst_zero", {63'd0, zero}, 64'd1);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].r, vecs[i].c, vecs[i].v);
    end

    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      e  = model(ra, rb, rs);
      op(ra, rb, rs, e.r, e.c, e.v);
    end

    // Start pulsed during RUN must not disturb the operation in flight.
    @(negedge clk);
    start = 1'b1; a = 64'h0000_0000_0000_FFFF; b = 64'd1; sub = 1'b0;
    e.r = 64'h0000_0000_0001_0000; e.c = 1'b0; e.v = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 64'h1111_2222_3333_4444; b = 64'h5555_6666_7777_8888; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ign_latency", 64'(n), 64'd5);
    repeat (3) begin
      @(negedge clk);
      chk("ign_no_requeue", {63'd0, busy}, 64'd0);
    end

    // Reset in the second RUN cycle aborts and clears.
    @(negedge clk);
    start = 1'b1; a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_1111_1111_1111; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_result", result, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_carry_out", {63'd0, carry_out}, 64'd0);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_done", {63'd0, done}, 64'd0);
    end

    // Back-to-back: new start in the DONE cycle.
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    issue(64'd1, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
